// File: rtl/banked_memory_pkg.sv
// Shared types and elaboration-time helpers for the banked memory.
package banked_memory_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // A single bank still gets a 1-bit select so W_Bank=1 can be flagged.
  function automatic int bsel_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/banked_memory_mem_bank.sv
// One bank: synchronous write, registered read-first read, no reset on the
// array or read register so it maps onto block RAM.
module mem_bank
  import banked_memory_pkg::*;
#(
  parameter int DATA_WIDTH = 9,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/banked_memory.sv
// N-bank RAM: one-bank writes, all-bank parallel reads with one-cycle latency,
// and a clear sequencer that zeroes every bank after reset or on Clr.
module banked_memory
  import banked_memory_pkg::*;
#(
  parameter int  DATA_WIDTH = 9,
  parameter int  ADDR_WIDTH = 4,
  parameter int  NUM_BANKS  = 2,
  localparam int BSEL_WIDTH = bsel_width(NUM_BANKS)
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic                            Clr,
  input  logic                            W_En,
  input  logic [BSEL_WIDTH-1:0]           W_Bank,
  input  logic [ADDR_WIDTH-1:0]           W_Addr,
  input  logic [DATA_WIDTH-1:0]           Data_In,
  input  logic                            R_En,
  input  logic [ADDR_WIDTH-1:0]           R_Addr,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] Data_O,
  output logic                            R_Valid,
  output logic                            Busy,
  output logic                            W_Err
);

  localparam logic [BSEL_WIDTH:0] BANK_LIMIT = (BSEL_WIDTH + 1)'(NUM_BANKS);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
  logic                  r_valid_reg;
  logic                  w_err_reg;
  logic                  shown_reg;

  logic                  busy;
  logic                  bank_ok;
  logic                  wr_ok;
  logic                  rd;
  logic [ADDR_WIDTH-1:0] bank_addr;
  logic [DATA_WIDTH-1:0] bank_wdata;
  logic [NUM_BANKS-1:0]  bank_we;
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      CLEAR: begin
        if (Clr) begin
          cnt_next = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == '1) begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (Clr) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = CLEAR;
        cnt_next   = '0;
      end
    endcase
  end

  assign busy    = (state_reg == CLEAR);
  assign bank_ok = ({1'b0, W_Bank} < BANK_LIMIT);
  assign wr_ok   = !busy && W_En && bank_ok;
  assign rd      = !busy && R_En;

  // While clearing, the sequencer owns every bank's write port.
  assign bank_addr  = busy ? cnt_reg : W_Addr;
  assign bank_wdata = busy ? '0 : Data_In;

  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      assign bank_we[gi] = busy || (wr_ok && (W_Bank == BSEL_WIDTH'(gi)));

      mem_bank #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
      ) u_bank (
        .clk  (Clk),
        .we   (bank_we[gi]),
        .waddr(bank_addr),
        .wdata(bank_wdata),
        .re   (rd),
        .raddr(R_Addr),
        .rdata(bank_rdata[gi])
      );

      // The RAM read register has no reset; mask it until the first real read.
      assign Data_O[gi*DATA_WIDTH +: DATA_WIDTH] = shown_reg ? bank_rdata[gi] : '0;
    end
  endgenerate

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_valid_reg <= 1'b0;
      w_err_reg   <= 1'b0;
      shown_reg   <= 1'b0;
    end else begin
      r_valid_reg <= rd;
      shown_reg   <= shown_reg || rd;
      if (Clr) begin
        w_err_reg <= 1'b0;
      end else if (!busy && W_En && !bank_ok) begin
        w_err_reg <= 1'b1;
      end
    end
  end

  assign R_Valid = r_valid_reg;
  assign Busy    = busy;
  assign W_Err   = w_err_reg;

endmodule

// File: tb/tb_banked_memory.sv
// Drives a 2-bank and a 3-bank instance with shared stimulus and compares both
// against an array-based reference model of the memory's documented behaviour.
module tb_banked_memory;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Clr = 1'b0;
  logic        W_En = 1'b0;
  logic        W_Bank_a = 1'b0;
  logic [1:0]  W_Bank_b = 2'd0;
  logic [3:0]  W_Addr = 4'd0;
  logic [8:0]  Data_In = 9'd0;
  logic        R_En = 1'b0;
  logic [3:0]  R_Addr = 4'd0;

  logic [17:0] Data_O_a;
  logic [26:0] Data_O_b;
  logic        R_Valid_a, Busy_a, W_Err_a;
  logic        R_Valid_b, Busy_b, W_Err_b;

  banked_memory dut_a (
    .Clk(Clk), .Rst(Rst), .Clr(Clr), .W_En(W_En), .W_Bank(W_Bank_a),
    .W_Addr(W_Addr), .Data_In(Data_In), .R_En(R_En), .R_Addr(R_Addr),
    .Data_O(Data_O_a), .R_Valid(R_Valid_a), .Busy(Busy_a), .W_Err(W_Err_a)
  );

  banked_memory #(.NUM_BANKS(3)) dut_b (
    .Clk(Clk), .Rst(Rst), .Clr(Clr), .W_En(W_En), .W_Bank(W_Bank_b),
    .W_Addr(W_Addr), .Data_In(Data_In), .R_En(R_En), .R_Addr(R_Addr),
    .Data_O(Data_O_b), .R_Valid(R_Valid_b), .Busy(Busy_b), .W_Err(W_Err_b)
  );

  always #5 Clk = ~Clk;

  // Reference model: memory contents plus expected visible outputs.
  logic [8:0]  mem_a [2][16];
  logic [8:0]  mem_b [3][16];
  logic [17:0] exp_da;
  logic [26:0] exp_db;
  logic        exp_rv;
  logic        exp_werr_b;
  int          clr_left;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic zero_model();
    for (int k = 0; k < 2; k++) for (int i = 0; i < 16; i++) mem_a[k][i] = 9'd0;
    for (int k = 0; k < 3; k++) for (int i = 0; i < 16; i++) mem_b[k][i] = 9'd0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".busy_a"}, {31'd0, Busy_a}, {31'd0, clr_left > 0});
    chk({tag, ".busy_b"}, {31'd0, Busy_b}, {31'd0, clr_left > 0});
    chk({tag, ".rvalid_a"}, {31'd0, R_Valid_a}, {31'd0, exp_rv});
    chk({tag, ".rvalid_b"}, {31'd0, R_Valid_b}, {31'd0, exp_rv});
    chk({tag, ".data_a"}, {14'd0, Data_O_a}, {14'd0, exp_da});
    chk({tag, ".data_b"}, {5'd0, Data_O_b}, {5'd0, exp_db});
    chk({tag, ".werr_a"}, {31'd0, W_Err_a}, 32'd0);
    chk({tag, ".werr_b"}, {31'd0, W_Err_b}, {31'd0, exp_werr_b});
  endtask

  // Asynchronous reset: outputs must reach reset values without a clock edge.
  task automatic apply_reset(input string tag);
    Rst = 1'b1;
    zero_model();
    exp_da = '0;
    exp_db = '0;
    exp_rv = 1'b0;
    exp_werr_b = 1'b0;
    clr_left = 16;
    #1;
    check_all(tag);
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
  endtask

  task automatic step(input string tag, input bit we, input bit ba, input logic [1:0] bb,
                      input logic [3:0] wa, input logic [8:0] wd,
                      input bit re, input logic [3:0] ra, input bit clr);
    bit busy;
    W_En = we; W_Bank_a = ba; W_Bank_b = bb; W_Addr = wa; Data_In = wd;
    R_En = re; R_Addr = ra; Clr = clr;
    busy = (clr_left > 0);
    exp_rv = !busy && re;
    if (exp_rv) begin
      for (int k = 0; k < 2; k++) exp_da[k*9 +: 9] = mem_a[k][ra];
      for (int k = 0; k < 3; k++) exp_db[k*9 +: 9] = mem_b[k][ra];
    end
    if (!busy && we) begin
      mem_a[ba][wa] = wd;
      if (bb < 2'd3) mem_b[bb][wa] = wd;
      else exp_werr_b = 1'b1;
    end
    if (clr) begin
      zero_model();
      clr_left = 16;
      exp_werr_b = 1'b0;
    end else if (clr_left > 0) begin
      clr_left--;
    end
    @(posedge Clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 2'd0, 4'd0, 9'd0, 0, 4'd0, 0);
  endtask

  task automatic read(input string tag, input logic [3:0] ra);
    step(tag, 0, 0, 2'd0, 4'd0, 9'd0, 1, ra, 0);
  endtask

  initial begin
    // 1: reset, clear lasts 16 cycles, then everything reads zero.
    apply_reset("reset0");
    for (int i = 0; i < 16; i++) idle("clear0");
    for (int i = 0; i < 16; i++) read("zero_sweep", 4'(i));

    // 2: write both banks at addr3, read back in parallel.
    step("wr_b0", 1, 0, 2'd0, 4'd3, 9'h1A5, 0, 4'd0, 0);
    step("wr_b1", 1, 1, 2'd1, 4'd3, 9'h0F0, 0, 4'd0, 0);
    step("wr_b2", 1, 0, 2'd2, 4'd3, 9'h133, 0, 4'd0, 0);
    read("rd_addr3", 4'd3);

    // 3: read-first on a same-cycle collision.
    step("wr_old", 1, 0, 2'd0, 4'd7, 9'h011, 0, 4'd0, 0);
    step("rw_same", 1, 0, 2'd0, 4'd7, 9'h055, 1, 4'd7, 0);
    read("rd_after", 4'd7);

    // 4: out-of-range bank sets sticky error; Clr clears it and the memory.
    step("bad_bank", 1, 0, 2'd3, 4'd5, 9'h1FF, 0, 4'd0, 0);
    read("rd_bad", 4'd5);
    idle("sticky");
    step("clr_run", 0, 0, 2'd0, 4'd0, 9'd0, 0, 4'd0, 1);
    for (int i = 0; i < 16; i++) idle("clear1");
    for (int i = 0; i < 16; i++) read("zero_sweep1", 4'(i));

    // 5: reset mid-clear; requests during busy are ignored.
    step("wr_pre", 1, 1, 2'd2, 4'd9, 9'h0AB, 0, 4'd0, 0);
    step("clr_run2", 0, 0, 2'd0, 4'd0, 9'd0, 0, 4'd0, 1);
    for (int i = 0; i < 8; i++) idle("clear2");
    apply_reset("reset_mid");
    for (int i = 0; i < 16; i++)
      step("busy_req", 1, 1, 2'(i % 3), 4'(i), 9'(i + 1), 1, 4'(i), 0);
    for (int i = 0; i < 16; i++) read("zero_sweep2", 4'(i));

    // 6: fill with random data, then back-to-back read sweep.
    for (int i = 0; i < 16; i++)
      step("fill", 1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 4'(i),
           9'($urandom), 0, 4'd0, 0);
    for (int i = 0; i < 16; i++) read("sweep", 4'(i));

    // Randomized traffic with frequent address collisions.
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 9'($urandom),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
           ($urandom_range(0, 49) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
